// File: rtl/psum_accumulator.sv
// Accumulates NUM_TILES signed partial-sum beats per output pixel across LANES channels.
// Define PSUM_ACC_SAT_EN to saturate results to OUT_DW; otherwise results wrap (low OUT_DW bits).

module psum_acc_lane #(
  parameter int IN_DW  = 16,
  parameter int ACC_DW = 20,
  parameter int OUT_DW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_beat,
  input  logic              i_first,
  input  logic              i_last,
  input  logic [IN_DW-1:0]  i_din,
  output logic [OUT_DW-1:0] o_dout
);
  logic signed [ACC_DW-1:0] r_acc;
  logic signed [ACC_DW-1:0] w_base;
  logic signed [ACC_DW-1:0] w_sum;
  logic        [OUT_DW-1:0] r_dout;
  logic        [OUT_DW-1:0] w_red;

  // A first beat ignores whatever the previous group left in the accumulator.
  assign w_base = i_first ? '0 : r_acc;
  assign w_sum  = w_base + {{(ACC_DW-IN_DW){i_din[IN_DW-1]}}, i_din};

`ifdef PSUM_ACC_SAT_EN
  localparam logic signed [ACC_DW-1:0] MAXV = {{(ACC_DW-OUT_DW+1){1'b0}}, {(OUT_DW-1){1'b1}}};
  localparam logic signed [ACC_DW-1:0] MINV = {{(ACC_DW-OUT_DW+1){1'b1}}, {(OUT_DW-1){1'b0}}};
  always_comb begin
    w_red = w_sum[OUT_DW-1:0];
    if (w_sum > MAXV)      w_red = MAXV[OUT_DW-1:0];
    else if (w_sum < MINV) w_red = MINV[OUT_DW-1:0];
  end
`else
  assign w_red = w_sum[OUT_DW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_dout <= '0;
    end else if (i_beat) begin
      if (i_last) r_dout <= w_red;
      else        r_acc  <= w_sum;
    end
  end

  assign o_dout = r_dout;
endmodule

module psum_accumulator #(
  parameter int LANES     = 64,
  parameter int IN_DW     = 16,
  parameter int ACC_DW    = 20,
  parameter int OUT_DW    = 16,
  parameter int NUM_TILES = 4,
  localparam int TW       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic                         data_e,
  input  logic [LANES-1:0][IN_DW-1:0]  data_in,
  output logic [LANES-1:0][OUT_DW-1:0] data_out,
  output logic                         data_e_out,
  output logic [TW-1:0]                tile_idx
);
  typedef enum logic {IDLE, ACCUM} state_t;

  state_t        r_state;
  logic [TW-1:0] r_tile;
  logic          r_vld;
  logic          w_beat;
  logic          w_first;
  logic          w_last;

  assign w_beat  = mode & data_e;
  assign w_first = (r_state == IDLE);
  assign w_last  = (r_tile == TW'(NUM_TILES-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tile  <= '0;
      r_vld   <= 1'b0;
    end else if (!mode) begin
      r_state <= IDLE;
      r_tile  <= '0;
      r_vld   <= 1'b0;
    end else if (data_e) begin
      if (w_last) begin
        r_state <= IDLE;
        r_tile  <= '0;
        r_vld   <= 1'b1;
      end else begin
        r_state <= ACCUM;
        r_tile  <= r_tile + TW'(1);
        r_vld   <= 1'b0;
      end
    end else begin
      r_vld <= 1'b0;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    psum_acc_lane #(
      .IN_DW (IN_DW),
      .ACC_DW(ACC_DW),
      .OUT_DW(OUT_DW)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_beat (w_beat),
      .i_first(w_first),
      .i_last (w_last),
      .i_din  (data_in[g]),
      .o_dout (data_out[g])
    );
  end

  assign data_e_out = r_vld;
  assign tile_idx   = r_tile;
endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized + directed bench for psum_accumulator against a per-group arithmetic model.
// Honors PSUM_ACC_SAT_EN to select the expected width reduction.

module tb_psum_accumulator;
  localparam int LANES = 64;
  localparam int IN_DW = 16;
  localparam int ACC_DW = 20;
  localparam int OUT_DW = 16;
  localparam int NT = 4;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic data_e = 1'b0;
  logic [LANES-1:0][IN_DW-1:0]  data_in = '0;
  logic [LANES-1:0][OUT_DW-1:0] data_out;
  logic data_e_out;
  logic [TW-1:0] tile_idx;

  always #5 clk = ~clk;

  psum_accumulator #(
    .LANES(LANES), .IN_DW(IN_DW), .ACC_DW(ACC_DW), .OUT_DW(OUT_DW), .NUM_TILES(NT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .data_e(data_e), .data_in(data_in),
    .data_out(data_out), .data_e_out(data_e_out), .tile_idx(tile_idx)
  );

  int n_chk = 0;
  int n_pass = 0;

  int m_cnt;
  int m_sum [LANES];
  int m_out [LANES];
  bit m_vld;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int red(input int s);
`ifdef PSUM_ACC_SAT_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    logic signed [OUT_DW-1:0] t;
    t = OUT_DW'(s);
    return int'(t);
`endif
  endfunction

  function automatic int lane_out(input int k);
    logic signed [OUT_DW-1:0] t;
    t = data_out[k];
    return int'(t);
  endfunction

  task automatic step(input bit r, input bit m, input bit de);
    rst_n = ~r; mode = m; data_e = de;
    @(posedge clk); #1;
    if (r) begin
      m_cnt = 0; m_vld = 0;
      for (int k = 0; k < LANES; k++) m_out[k] = 0;
    end else if (!m) begin
      m_cnt = 0; m_vld = 0;
    end else if (de) begin
      for (int k = 0; k < LANES; k++) begin
        logic signed [IN_DW-1:0] d;
        d = data_in[k];
        m_sum[k] = ((m_cnt == 0) ? 0 : m_sum[k]) + int'(d);
      end
      m_cnt++; m_vld = 0;
      if (m_cnt == NT) begin
        m_cnt = 0; m_vld = 1;
        for (int k = 0; k < LANES; k++) m_out[k] = red(m_sum[k]);
      end
    end else begin
      m_vld = 0;
    end
    chk("tile_idx", longint'(tile_idx), m_cnt);
    chk("data_e_out", longint'(data_e_out), m_vld);
    for (int k = 0; k < LANES; k++) chk($sformatf("data_out[%0d]", k), lane_out(k), m_out[k]);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1);
  endtask

  initial begin
    // reset
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("rst_tile", longint'(tile_idx), 0);
    chk("rst_vld", longint'(data_e_out), 0);
    chk("rst_d0", lane_out(0), 0);

    // basic group
    data_in = '0;
    data_in[63] = -16'sd5;
    data_in[0] = 16'sd3;  step(0, 1, 1); chk("basic_t1", longint'(tile_idx), 1);
    data_in[0] = -16'sd1; step(0, 1, 1); chk("basic_t2", longint'(tile_idx), 2);
    data_in[0] = 16'sd7;  step(0, 1, 1); chk("basic_t3", longint'(tile_idx), 3);
    data_in[0] = 16'sd2;  step(0, 1, 1); chk("basic_t0", longint'(tile_idx), 0);
    chk("basic_vld", longint'(data_e_out), 1);
    chk("basic_d0", lane_out(0), 11);
    chk("basic_d63", lane_out(63), -20);
    step(0, 1, 0);
    chk("basic_pulse1", longint'(data_e_out), 0);

    // reset mid-group
    data_in = '0; data_in[0] = 16'sd9;
    beats(2);
    step(1, 1, 1);
    chk("midrst_tile", longint'(tile_idx), 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    chk("midrst_vld", longint'(data_e_out), 0);

    // gapped then back-to-back
    data_in = '0; data_in[5] = 16'sd1;
    beats(2);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("gap_tile", longint'(tile_idx), 2);
    beats(2);
    chk("gap_vld", longint'(data_e_out), 1);
    chk("gap_d5", lane_out(5), 4);
    data_in[5] = 16'sd2;
    step(0, 1, 1);
    chk("b2b_pulse1", longint'(data_e_out), 0);
    beats(3);
    chk("b2b_vld", longint'(data_e_out), 1);
    chk("b2b_d5", lane_out(5), 8);

    // abort
    data_in = '0; data_in[0] = 16'sd100;
    beats(2);
    step(0, 0, 1);
    chk("abort_tile", longint'(tile_idx), 0);
    chk("abort_hold", lane_out(0), 0);
    data_in[0] = 16'sd1;
    beats(4);
    chk("abort_vld", longint'(data_e_out), 1);
    chk("abort_d0", lane_out(0), 4);

    // width reduction
    data_in = '0; data_in[0] = 16'sd30000; data_in[1] = -16'sd30000;
    beats(4);
`ifdef PSUM_ACC_SAT_EN
    chk("red_d0", lane_out(0), 32767);
    chk("red_d1", lane_out(1), -32768);
`else
    chk("red_d0", lane_out(0), -11072);
    chk("red_d1", lane_out(1), 11072);
`endif

    // mode gating
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < LANES; k++) data_in[k] = IN_DW'($urandom);
      step(0, 0, 1);
      chk("gate_tile", longint'(tile_idx), 0);
      chk("gate_vld", longint'(data_e_out), 0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit r, m, de;
      for (int k = 0; k < LANES; k++) data_in[k] = IN_DW'($urandom);
      if (($urandom % 4) == 0) begin
        data_in[2] = 16'sd32767;
        data_in[3] = -16'sd32768;
      end
      r  = ($urandom_range(0, 63) == 0);
      m  = ($urandom_range(0, 15) != 0);
      de = ($urandom_range(0, 3) != 0);
      step(r, m, de);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the per-macro partial-sum stage.
- Consumes its 64-lane signed 16-bit partial sums, one beat per input-channel tile, and accumulates NUM_TILES consecutive beats per output pixel in a widened register.
- After the final tile, emits one 64-lane result with width reduction and a single-cycle valid pulse to the next stage (BN/activation).

Parameters:
- LANES, 64, number of output channels processed in parallel
- IN_DW, 16, signed width of each incoming partial sum
- ACC_DW, 20, signed internal accumulator width; must be at least IN_DW + clog2(NUM_TILES)
- OUT_DW, 16, signed width of each emitted result
- NUM_TILES, 4, beats accumulated per output; legal range 1..16

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active LOW
- mode  in  1  LOW = reload parameters / idle; HIGH = calculate
- data_e  in  1  input beat valid, active HIGH
- data_in  in  LANES x IN_DW  signed partial sums, lane k = output channel k
- data_out  out  LANES x OUT_DW  signed accumulated results, registered
- data_e_out  out  1  result valid, one-cycle pulse
- tile_idx  out  clog2(NUM_TILES) (min 1)  index of the next expected tile beat, for debug/upstream alignment

Behaviour:
- Interface: one clock, clk. rst_n is synchronous and active-LOW; it is sampled only on the rising edge of clk.
- Reset (rst_n LOW at a clk edge):
  - acc[*], data_out[*] = 0
  - data_e_out = 0
  - tile_idx = 0
  - state = IDLE
- States:
  - IDLE: tile_idx == 0, no partial accumulation held.
  - ACCUM: 0 < tile_idx < NUM_TILES.
- Beat accepted: mode HIGH and data_e HIGH at a clk edge. No backpressure: every accepted beat is consumed.
- Accepted beat with tile_idx == 0:
  - acc[k] <= sign-extended data_in[k]
  - if NUM_TILES > 1: tile_idx <= 1, state -> ACCUM
- Accepted beat with 0 < tile_idx < NUM_TILES-1: acc[k] <= acc[k] + sext(data_in[k]); tile_idx++.
- Accepted beat with tile_idx == NUM_TILES-1 (final beat; includes tile_idx 0 when NUM_TILES == 1):
  - data_out[k] <= reduce(acc[k] + sext(data_in[k])), or reduce(sext(data_in[k])) when NUM_TILES == 1
  - data_e_out <= 1 on the next edge
  - tile_idx <= 0, state -> IDLE
  - acc is not required to be cleared; the next first beat overwrites it.
- Latency: data_out and data_e_out update on the clk edge that accepts the final beat, i.e. visible one cycle after that beat is presented.
- data_e_out is HIGH for exactly one cycle per completed group. Back-to-back groups (final beat immediately followed by the next group's first beat) are supported at full rate, with no bubble.
- data_e LOW while mode HIGH: acc, tile_idx and data_out hold; data_e_out <= 0. Gaps between beats of a group are allowed.
- mode LOW at any edge (including mid-group) aborts the group:
  - tile_idx <= 0, state -> IDLE, data_e_out <= 0
  - data_out holds its last value; acc contents are don't-care
  - data_e is ignored while mode is LOW.
- reset asserted mid-group: full reset as above; no result is emitted for the partial group.
- Arithmetic: all sums two's complement at ACC_DW. No internal overflow is possible under the legal ACC_DW constraint. reduce() is defined under Optional Feature.

Optional Feature:
- Macro: PSUM_ACC_SAT_EN.
- Defined: reduce() saturates the ACC_DW value to the signed OUT_DW range, [-2^(OUT_DW-1), 2^(OUT_DW-1)-1] = [-32768, 32767] by default.
- Undefined: reduce() takes the low OUT_DW bits (wrap-around truncation). No saturation logic is synthesized.

Test Plan:
- Reset, then release: all data_out = 0, data_e_out = 0, tile_idx = 0. Hold rst_n LOW for one edge mid-group after 2 beats: tile_idx returns to 0 and no data_e_out pulse follows.
- Basic group: mode HIGH, 4 consecutive beats with lane 0 = 3, -1, 7, 2 and lane 63 = -5 each beat -> one cycle after beat 4, data_e_out = 1 for one cycle, data_out[0] = 11, data_out[63] = -20; tile_idx sequence 0,1,2,3,0.
- Gapped and back-to-back groups: 4 beats of lane 5 = 1 with data_e LOW for 3 cycles between beats 2 and 3 -> single pulse, data_out[5] = 4. Immediately follow with 4 beats of lane 5 = 2 -> next pulse, data_out[5] = 8, with no idle cycle required.
- Abort: 2 beats of lane 0 = 100, then mode LOW for 1 cycle, then mode HIGH and 4 beats of lane 0 = 1 -> single pulse, data_out[0] = 4 (not 204); data_out holds its prior value during the abort.
- Width reduction: 4 beats of lane 0 = 30000 (sum 120000) and lane 1 = -30000 -> with PSUM_ACC_SAT_EN: data_out[0] = 32767, data_out[1] = -32768. Without it: data_out[0] = -11072 (0xD4C0), data_out[1] = 11072.
- Mode gating: data_e HIGH for 6 cycles while mode LOW -> tile_idx stays 0 and data_e_out stays 0 throughout.
